// File: rtl/serial_pattern_tx.sv
// rtl/serial_pattern_tx.sv - sync+payload(+parity) serial frame transmitter with repeat and idle gap
// Optional trailing even-parity bit: define SERIAL_PATTERN_TX_PARITY_EN.
module serial_pattern_tx #(
    parameter int               DATA_W   = 8,
    parameter int               SYNC_W   = 4,
    parameter logic [SYNC_W-1:0] SYNC_PAT = 4'b1101,
    parameter int               GAP_LEN  = 2
) (
    input  logic              CLK,
    input  logic              rst_n,
    input  logic              start,
    input  logic [DATA_W-1:0] data,
    input  logic [3:0]        rpt,
    output logic              ready,
    output logic              out,
    output logic              out_valid,
    output logic              done,
    output logic [7:0]        frame_cnt
);

    localparam int CNT_W = 6;
    localparam int GAP_W = 16;
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_W - 1);
    localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SYNC,
        S_DATA,
`ifdef SERIAL_PATTERN_TX_PARITY_EN
        S_PAR,
`endif
        S_GAP
    } state_t;

    state_t             state;
    logic [DATA_W-1:0]  data_q;
    logic [3:0]         rep_left;
    logic [CNT_W-1:0]   cnt;
    logic [GAP_W-1:0]   gap_cnt;

    logic [CNT_W-1:0]   cnt_m1;
    logic               sync_bit;
    logic               data_bit;
    logic               last_bit;

    // cnt counts the bits still to follow the one currently on out
    assign cnt_m1   = cnt - CNT_W'(1);
    assign sync_bit = |(SYNC_PAT & (SYNC_W'(1) << cnt_m1));
    assign data_bit = |(data_q & (DATA_W'(1) << cnt_m1));

`ifdef SERIAL_PATTERN_TX_PARITY_EN
    assign last_bit = (state == S_PAR);
`else
    assign last_bit = (state == S_DATA) && (cnt == '0);
`endif

    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            out       <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            ready     <= 1'b1;
            frame_cnt <= 8'd0;
            data_q    <= '0;
            rep_left  <= 4'd0;
            cnt       <= '0;
            gap_cnt   <= '0;
        end else begin
            done <= 1'b0;
            if (last_bit) begin
                frame_cnt <= frame_cnt + 8'd1;
                out       <= 1'b0;
                out_valid <= 1'b0;
                cnt       <= '0;
                if (rep_left != 4'd0) begin
                    rep_left <= rep_left - 4'd1;
                    gap_cnt  <= GAP_LAST;
                    state    <= S_GAP;
                end else begin
                    state <= S_IDLE;
                    ready <= 1'b1;
                    done  <= 1'b1;
                end
            end else begin
                case (state)
                    S_IDLE: begin
                        if (start) begin
                            data_q    <= data;
                            rep_left  <= rpt;
                            cnt       <= SYNC_LAST;
                            out       <= SYNC_PAT[SYNC_W-1];
                            out_valid <= 1'b1;
                            ready     <= 1'b0;
                            state     <= S_SYNC;
                        end
                    end
                    S_SYNC: begin
                        if (cnt != '0) begin
                            out <= sync_bit;
                            cnt <= cnt_m1;
                        end else begin
                            out   <= data_q[DATA_W-1];
                            cnt   <= DATA_LAST;
                            state <= S_DATA;
                        end
                    end
                    S_DATA: begin
                        if (cnt != '0) begin
                            out <= data_bit;
                            cnt <= cnt_m1;
                        end
`ifdef SERIAL_PATTERN_TX_PARITY_EN
                        else begin
                            out   <= ^data_q;
                            state <= S_PAR;
                        end
`endif
                    end
                    S_GAP: begin
                        // same latched payload is resent after the gap
                        if (gap_cnt != '0) begin
                            gap_cnt <= gap_cnt - GAP_W'(1);
                        end else begin
                            cnt       <= SYNC_LAST;
                            out       <= SYNC_PAT[SYNC_W-1];
                            out_valid <= 1'b1;
                            state     <= S_SYNC;
                        end
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: doc/serial_pattern_tx.md
# serial_pattern_tx

- Frame transmitter that drives a single-bit serial line toward the Mealy sequence detector.
- On a start request it emits the sync pattern 1101, then a latched payload word MSB-first, optionally followed by a parity bit.
- It can repeat the frame a programmed number of times, with a fixed idle gap between frames.
- It is the stimulus end of the detector link and serves as the bit source for on-board loopback tests.

## Interface
Parameters:
- DATA_W, 8, payload width in bits (legal range 1–32)
- SYNC_PAT, 4'b1101, sync pattern, sent MSB-first
- SYNC_W, 4, sync pattern width
- GAP_LEN, 2, number of idle cycles between repeated frames (≥1)

Ports:
- CLK  in  1  clock, all state on rising edge
- rst_n  in  1  reset, asynchronous, active-low
- start  in  1  frame request, sampled only when ready=1
- data  in  DATA_W  payload, latched on accepted start
- rpt  in  4  extra repetitions (0 = send once, 15 = send 16 times), latched on accepted start
- ready  out  1  high only in IDLE
- out  out  1  serial bit, registered
- out_valid  out  1  high while out carries a sync, payload or parity bit
- done  out  1  one-cycle pulse after the final bit of the final frame
- frame_cnt  out  8  count of completed frames since reset

## Operation
States:
- IDLE: wait for start.
- SYNC: shift SYNC_W bits of SYNC_PAT, MSB first.
- DATA: shift DATA_W bits of the latched data, MSB first.
- PAR: one parity bit (only when the parity macro is defined).
- GAP: GAP_LEN cycles with out=0, out_valid=0.

Transitions:
- IDLE→SYNC on start=1. data and rpt are captured into shift and repeat registers in the same edge.
- SYNC→DATA after SYNC_W bits.
- DATA→PAR (if enabled), otherwise frame end, after DATA_W bits.
- At frame end:
  - rep_left>0: decrement rep_left and go to GAP.
  - rep_left=0: go to IDLE.
- GAP→SYNC after GAP_LEN cycles; the same latched payload is resent.

Outputs and counters:
- frame_cnt increments by 1 at every frame end and wraps 255→0.
- start while ready=0 is ignored; it is not queued.
- In IDLE and GAP: out=0, out_valid=0.
- Changes on data or rpt after acceptance do not affect the frame in flight.
- Reset values: state=IDLE, out=0, out_valid=0, done=0, ready=1, frame_cnt=0, shift, bit and repeat counters all 0.
- Reset asserted mid-frame immediately forces the reset values; the partial frame is not counted and done does not fire.

## Timing
- Latency: start accepted at edge N puts the first sync bit on out after edge N (1 cycle). ready falls in the same edge.
- Frame length F = SYNC_W + DATA_W (+1 with parity) cycles of out_valid=1, with no bubbles inside a frame.
- Total busy time from accept to IDLE = (rpt+1)·F + rpt·GAP_LEN cycles.
- done=1 and ready=1 appear together in the cycle after the last valid bit. A start in that cycle is accepted, so back-to-back transactions are allowed, with no idle cycle guaranteed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Configuration
- SERIAL_PATTERN_TX_PARITY_EN defined:
  - PAR state is compiled in.
  - After the last payload bit, one cycle carries the even parity (XOR of all DATA_W payload bits) with out_valid=1.
  - F = SYNC_W + DATA_W + 1.
- Undefined:
  - No PAR state.
  - F = SYNC_W + DATA_W.
  - No parity logic is present.

## Test plan
- DATA_W=8, data=8'hA5, rpt=0, no parity:
  - out over 12 valid cycles = 1101_10100101.
  - done pulses in cycle 13.
  - frame_cnt=1, ready=1.
- Same with SERIAL_PATTERN_TX_PARITY_EN: 13 valid bits, last bit 0 (A5 has four ones). data=8'h07 gives last bit 1.
- rpt=2, data=8'h3C:
  - three frames separated by exactly 2 idle cycles.
  - done pulses once, after frame 3.
  - frame_cnt=3, total busy 3·12+2·2=40 cycles.
- start pulsed during DATA with data=8'hFF: ignored, the in-flight payload is unchanged. Back-to-back start in the done cycle is accepted with no gap.
- rst_n low for 1 cycle mid-DATA:
  - out and out_valid go 0 asynchronously, before the next edge.
  - frame_cnt keeps its pre-frame value (0 after reset).
  - no done pulse.
  - a new start afterwards produces a clean frame.
- Loopback into the detector with data=8'h00 and idle zeros before:
  - detector out fires exactly once per frame, on the 4th sync bit.
  - After 256 frames, frame_cnt wraps to 0.
